sonar_sweep_sequencer: RTL

Ping scheduler for the sonar front end, and the parametrised successor of the fixed pwm/evt_counter burst timing in the top level. It runs repeating burst/blank/listen/report pings, steps the beam angle per ping (static, ping-pong or sawtooth sweep), and paces ADC sample triggers during listen. It also thresholds the beamformed waveform and reports per-ping angle, time-of-flight, hit flag and peak amplitude. It feeds `sin_lut`, `transmit_beamformer`, `spi_con` and the display/velocity consumers.

---
 rtl/sonar_pkg.sv | 21 ++
 rtl/sweep_angle_stepper.sv | 84 ++++++++
 rtl/sonar_sweep_sequencer.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/sonar_pkg.sv
// Shared types and default widths for the sonar ping sequencer.
package sonar_pkg;

   localparam int unsigned DEF_ANGLE_WIDTH  = 7;
   localparam int unsigned DEF_SAMPLE_WIDTH = 16;

   typedef enum logic [1:0] {
      SCAN_STATIC   = 2'd0,
      SCAN_PINGPONG = 2'd1,
      SCAN_SAW      = 2'd2
   } scan_mode_t;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      BURST  = 3'd1,
      BLANK  = 3'd2,
      LISTEN = 3'd3,
      REPORT = 3'd4
   } state_t;

endpackage

// File: rtl/sweep_angle_stepper.sv
// Beam angle register: loads on ping start, steps once per report according to sweep mode.
module sweep_angle_stepper
   import sonar_pkg::*;
#(
   parameter int unsigned ANGLE_WIDTH = DEF_ANGLE_WIDTH,
   parameter int          ANGLE_MIN   = -30,
   parameter int          ANGLE_MAX   = 30,
   parameter int unsigned ANGLE_STEP  = 10
)(
   input  logic                   clk,
   input  logic                   rst,
   input  logic [1:0]             mode,
   input  logic [ANGLE_WIDTH-1:0] static_angle,
   input  logic                   step,
   input  logic                   load,
   output logic [ANGLE_WIDTH-1:0] angle
);

   localparam int unsigned XW = ANGLE_WIDTH + 2;
   localparam logic signed [XW-1:0] MIN_X  = XW'(ANGLE_MIN);
   localparam logic signed [XW-1:0] MAX_X  = XW'(ANGLE_MAX);
   localparam logic signed [XW-1:0] STEP_X = XW'(ANGLE_STEP);

   logic                   up, up_nxt;
   logic                   last_sweep;
   logic                   sweep;
   logic [ANGLE_WIDTH-1:0] angle_nxt;
   logic signed [XW-1:0]   cur_x, up_x, dn_x;

   // Candidate neighbours clamped to the sweep bounds
   always_comb begin
      cur_x = XW'($signed(angle));
      up_x  = cur_x + STEP_X;
      dn_x  = cur_x - STEP_X;
      if (up_x > MAX_X) up_x = MAX_X;
      if (dn_x < MIN_X) dn_x = MIN_X;
   end

   always_comb begin
      angle_nxt = angle;
      up_nxt    = up;
      sweep     = (mode == SCAN_PINGPONG) || (mode == SCAN_SAW);
      if (load || step) begin
         if (!sweep) begin
            angle_nxt = static_angle;
            up_nxt    = 1'b1;
         end else if (load || !last_sweep) begin
            angle_nxt = ANGLE_WIDTH'(MIN_X);
            up_nxt    = 1'b1;
         end else if (mode == SCAN_SAW) begin
            angle_nxt = (cur_x >= MAX_X) ? ANGLE_WIDTH'(MIN_X) : ANGLE_WIDTH'(up_x);
            up_nxt    = 1'b1;
         end else if (up) begin
            // Reverse at the top without repeating the endpoint
            if (cur_x >= MAX_X) begin
               angle_nxt = ANGLE_WIDTH'(dn_x);
               up_nxt    = 1'b0;
            end else begin
               angle_nxt = ANGLE_WIDTH'(up_x);
            end
         end else begin
            if (cur_x <= MIN_X) begin
               angle_nxt = ANGLE_WIDTH'(up_x);
               up_nxt    = 1'b1;
            end else begin
               angle_nxt = ANGLE_WIDTH'(dn_x);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         angle      <= '0;
         up         <= 1'b1;
         last_sweep <= 1'b0;
      end else begin
         angle <= angle_nxt;
         up    <= up_nxt;
         if (load || step) last_sweep <= sweep;
      end
   end

endmodule

// File: rtl/sonar_sweep_sequencer.sv
// Ping scheduler: burst/blank/listen/report timing, ADC trigger pacing and per-ping echo report.
module sonar_sweep_sequencer
   import sonar_pkg::*;
#(
   parameter int unsigned PERIOD_CYCLES = 16777216,
   parameter int unsigned BURST_CYCLES  = 524288,
   parameter int unsigned BLANK_CYCLES  = 50000,
   parameter int unsigned SAMPLE_DIV    = 100,
   parameter int unsigned ANGLE_WIDTH   = DEF_ANGLE_WIDTH,
   parameter int          ANGLE_MIN     = -30,
   parameter int          ANGLE_MAX     = 30,
   parameter int unsigned ANGLE_STEP    = 10,
   parameter int unsigned SAMPLE_WIDTH  = DEF_SAMPLE_WIDTH,
   localparam int unsigned TW           = $clog2(PERIOD_CYCLES)
)(
   input  logic                    clk_in,
   input  logic                    rst_in,
   input  logic                    enable_in,
   input  logic [1:0]              mode_in,
   input  logic [ANGLE_WIDTH-1:0]  static_angle_in,
   input  logic [SAMPLE_WIDTH-1:0] threshold_in,
   input  logic [SAMPLE_WIDTH-1:0] sample_in,
   input  logic                    sample_valid_in,
   output logic                    burst_out,
   output logic                    burst_start_out,
   output logic [ANGLE_WIDTH-1:0]  angle_out,
   output logic                    sample_trigger_out,
   output logic                    result_valid_out,
   output logic [ANGLE_WIDTH-1:0]  result_angle_out,
   output logic [TW-1:0]           result_tof_out,
   output logic                    result_hit_out,
   output logic [SAMPLE_WIDTH-1:0] result_peak_out
);

   localparam int unsigned    DW          = $clog2(SAMPLE_DIV + 1);
   localparam logic [TW-1:0]  BURST_LAST  = TW'(BURST_CYCLES - 1);
   localparam logic [TW-1:0]  BLANK_LAST  = TW'(BURST_CYCLES + BLANK_CYCLES - 1);
   localparam logic [TW-1:0]  LISTEN_LAST = TW'(PERIOD_CYCLES - 2);
   localparam logic [DW-1:0]  DIV_LAST    = DW'(SAMPLE_DIV - 1);

   state_t                  state, state_nxt;
   logic [TW-1:0]           cyc, cyc_nxt;
   logic [DW-1:0]           div, div_nxt;
   logic                    hit, hit_nxt;
   logic [TW-1:0]           tof, tof_nxt;
   logic [SAMPLE_WIDTH-1:0] peak, peak_nxt;
   logic                    load, step;
   logic                    burst_entry;
   logic                    trig_nxt;

   sweep_angle_stepper #(
      .ANGLE_WIDTH (ANGLE_WIDTH),
      .ANGLE_MIN   (ANGLE_MIN),
      .ANGLE_MAX   (ANGLE_MAX),
      .ANGLE_STEP  (ANGLE_STEP)
   ) u_stepper (
      .clk          (clk_in),
      .rst          (rst_in),
      .mode         (mode_in),
      .static_angle (static_angle_in),
      .step         (step),
      .load         (load),
      .angle        (angle_out)
   );

   // Next state; enable is only looked at in IDLE and REPORT
   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      step      = 1'b0;
      case (state)
         IDLE: begin
            if (enable_in) begin
               state_nxt = BURST;
               load      = 1'b1;
            end
         end
         BURST:  if (cyc == BURST_LAST)  state_nxt = (BLANK_CYCLES == 0) ? LISTEN : BLANK;
         BLANK:  if (cyc == BLANK_LAST)  state_nxt = LISTEN;
         LISTEN: if (cyc == LISTEN_LAST) state_nxt = REPORT;
         REPORT: begin
            step      = 1'b1;
            state_nxt = enable_in ? BURST : IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Ping counter, trigger divider and echo accumulators
   always_comb begin
      burst_entry = (state_nxt == BURST) && (state != BURST);
      if (burst_entry || (state_nxt == IDLE)) cyc_nxt = '0;
      else                                    cyc_nxt = cyc + TW'(1);

      if ((state != LISTEN) || (div == DIV_LAST)) div_nxt = '0;
      else                                         div_nxt = div + DW'(1);
      trig_nxt = (state_nxt == LISTEN) && (div_nxt == '0);

      hit_nxt  = hit;
      tof_nxt  = tof;
      peak_nxt = peak;
      if (burst_entry) begin
         hit_nxt  = 1'b0;
         tof_nxt  = '0;
         peak_nxt = '0;
      end else if ((state == LISTEN) && sample_valid_in) begin
         if (!hit && (sample_in > threshold_in)) begin
            hit_nxt = 1'b1;
            tof_nxt = cyc;
         end
         if (sample_in > peak) peak_nxt = sample_in;
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state              <= IDLE;
         cyc                <= '0;
         div                <= '0;
         hit                <= 1'b0;
         tof                <= '0;
         peak               <= '0;
         burst_out          <= 1'b0;
         burst_start_out    <= 1'b0;
         sample_trigger_out <= 1'b0;
         result_valid_out   <= 1'b0;
         result_angle_out   <= '0;
         result_tof_out     <= '0;
         result_hit_out     <= 1'b0;
         result_peak_out    <= '0;
      end else begin
         state              <= state_nxt;
         cyc                <= cyc_nxt;
         div                <= div_nxt;
         hit                <= hit_nxt;
         tof                <= tof_nxt;
         peak               <= peak_nxt;
         burst_out          <= (state_nxt == BURST);
         burst_start_out    <= burst_entry;
         sample_trigger_out <= trig_nxt;
         result_valid_out   <= (state_nxt == REPORT);
         // Report captures the last LISTEN sample via the accumulator next values
         if (state_nxt == REPORT) begin
            result_angle_out <= angle_out;
            result_tof_out   <= tof_nxt;
            result_hit_out   <= hit_nxt;
            result_peak_out  <= peak_nxt;
         end
      end
   end

endmodule
